// File: rtl/x_hazard_ctrl.sv
// Execute-stage hazard control: operand forwarding, load-use stall, branch/jump
// redirect with wrong-path slot kill, and the tohost CSR register.
module x_hazard_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned KILL_SLOTS = 1,
  parameter logic [11:0] CSR_TOHOST = 12'h51E
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            x_valid,
  input  logic [31:0]     x_inst,
  input  logic [XLEN-1:0] x_pc,
  input  logic [XLEN-1:0] x_imm,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            pc_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic [XLEN-1:0] csr_tohost
);

  localparam int unsigned CW = 2;
  localparam int unsigned RW = 5;
  localparam logic [CW-1:0] LD_INIT   = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] KILL_INIT = CW'(KILL_SLOTS - 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  typedef enum logic {RUN, LDWAIT} state_t;

  state_t state_q, state_d;

  logic [6:0]    opcode;
  logic [RW-1:0] rs1, rs2, rd;
  logic [2:0]    funct3;
  logic [11:0]   csr_addr;

  assign opcode   = x_inst[6:0];
  assign rd       = x_inst[11:7];
  assign funct3   = x_inst[14:12];
  assign rs1      = x_inst[19:15];
  assign rs2      = x_inst[24:20];
  assign csr_addr = x_inst[31:20];

  logic            hist_v  [FWD_DEPTH];
  logic [RW-1:0]   hist_rd [FWD_DEPTH];
  logic [XLEN-1:0] hist_d  [FWD_DEPTH];

  logic [CW-1:0]   ld_cnt_q, kill_cnt_q;
  logic [RW-1:0]   ld_rd_q;
  logic [XLEN-1:0] tohost_q;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic            kill_active, x_live, reads_ld, ev, br_taken, take;
  logic            is_load, is_store, is_branch, is_jal, is_jalr, is_csr;
  logic [XLEN-1:0] br_tgt, jalr_sum, jalr_tgt;

  // Oldest source first so that younger sources override it.
  always_comb begin
    fwd_a = rf_rs1_data;
    fwd_b = rf_rs2_data;
    for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
      if (hist_v[i] && (hist_rd[i] != '0) && (hist_rd[i] == rs1)) fwd_a = hist_d[i];
      if (hist_v[i] && (hist_rd[i] != '0) && (hist_rd[i] == rs2)) fwd_b = hist_d[i];
    end
    if (wb_valid && (wb_rd != '0) && (wb_rd == rs1)) fwd_a = wb_data;
    if (wb_valid && (wb_rd != '0) && (wb_rd == rs2)) fwd_b = wb_data;
    if (rs1 == '0) fwd_a = '0;
    if (rs2 == '0) fwd_b = '0;
  end

  assign op_a = reset_n ? fwd_a : rf_rs1_data;
  assign op_b = reset_n ? fwd_b : rf_rs2_data;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_csr    = (opcode == OPC_CSR);

  assign kill_active = (kill_cnt_q != '0);
  assign x_live      = reset_n & x_valid & ~kill_active;
  assign reads_ld    = (ld_rd_q != '0) && ((rs1 == ld_rd_q) || (rs2 == ld_rd_q));

  // Load-use FSM: next state and stall.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (x_live && reads_ld && (ld_cnt_q != '0)) begin
          stall   = 1'b1;
          state_d = LDWAIT;
        end
      end
      LDWAIT: begin
        if (ld_cnt_q != '0) stall = 1'b1;
        else                state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign ev = x_live & ~stall;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (fwd_a == fwd_b);
      3'b001:  br_taken = (fwd_a != fwd_b);
      3'b100:  br_taken = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  br_taken = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_taken = (fwd_a <  fwd_b);
      3'b111:  br_taken = (fwd_a >= fwd_b);
      default: br_taken = 1'b0;
    endcase
  end

  assign br_tgt   = x_pc + x_imm;
  assign jalr_sum = fwd_a + x_imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign take     = ev & ((is_branch & br_taken) | is_jal | is_jalr);

  assign pc_sel      = take;
  assign redirect_pc = take ? (is_jalr ? jalr_tgt : br_tgt) : '0;
  assign flush       = take | kill_active;
  assign dmem_re     = ev & is_load;
  assign dmem_we     = ev & is_store;
  assign csr_tohost  = tohost_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // Retired-write history shifts every cycle, stalls included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FWD_DEPTH); i++) begin
        hist_v[i]  <= 1'b0;
        hist_rd[i] <= '0;
        hist_d[i]  <= '0;
      end
    end else begin
      hist_v[0]  <= wb_valid;
      hist_rd[0] <= wb_rd;
      hist_d[0]  <= wb_data;
      for (int i = 1; i < int'(FWD_DEPTH); i++) begin
        hist_v[i]  <= hist_v[i-1];
        hist_rd[i] <= hist_rd[i-1];
        hist_d[i]  <= hist_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_cnt_q   <= '0;
      ld_rd_q    <= '0;
      kill_cnt_q <= '0;
    end else begin
      if (ev && is_load) begin
        ld_cnt_q <= LD_INIT;
        ld_rd_q  <= rd;
      end else if (ld_cnt_q != '0) begin
        ld_cnt_q <= ld_cnt_q - CW'(1);
      end
      if (take)             kill_cnt_q <= KILL_INIT;
      else if (kill_active) kill_cnt_q <= kill_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tohost_q <= '0;
    end else if (ev && is_csr && (csr_addr == CSR_TOHOST)) begin
      if (funct3 == 3'b001)      tohost_q <= fwd_a;
      else if (funct3 == 3'b101) tohost_q <= XLEN'(rs1);
    end
  end

endmodule

// File: tb/tb_x_hazard_ctrl.sv
// Bench for x_hazard_ctrl: two parameterisations share stimulus; a queue of
// expected values is drained and compared by an independent monitor.
module tb_x_hazard_ctrl;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] ADD_655 = 32'h00528333;  // add x6,x5,x5
  localparam logic [31:0] ADD_605 = 32'h00500333;  // add x6,x0,x5
  localparam logic [31:0] LW_3    = 32'h00012183;  // lw x3,0(x2)
  localparam logic [31:0] ADD_431 = 32'h00118233;  // add x4,x3,x1
  localparam logic [31:0] BLT     = 32'h0083C063;  // blt x7,x8
  localparam logic [31:0] BLTU    = 32'h0083E063;  // bltu x7,x8
  localparam logic [31:0] JALR    = 32'h000480E7;  // jalr x1,x9
  localparam logic [31:0] SW      = 32'h0021A023;  // sw x2,0(x3)
  localparam logic [31:0] CSRRW   = 32'h51E09073;  // csrrw x0,tohost,x1
  localparam logic [31:0] CSRRWI  = 32'h51E1D073;  // csrrwi x0,tohost,3
  localparam logic [31:0] CSRRS   = 32'h51E0A073;  // csrrs x0,tohost,x1

  localparam int OPA0 = 0,  OPB0 = 1,  STL0 = 2,  PCS0 = 3,  RPC0 = 4,  FLS0 = 5;
  localparam int DRE0 = 6,  DWE0 = 7,  CSR0 = 8,  OPA1 = 9,  OPB1 = 10, STL1 = 11;
  localparam int PCS1 = 12, FLS1 = 13, DRE1 = 14, DWE1 = 15, CSR1 = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            x_valid;
  logic [31:0]     x_inst;
  logic [XLEN-1:0] x_pc, x_imm, rf_rs1_data, rf_rs2_data, wb_data;
  logic            wb_valid;
  logic [4:0]      wb_rd;

  logic [XLEN-1:0] op_a0, op_b0, redirect_pc0, csr_tohost0;
  logic            stall0, pc_sel0, flush0, dmem_re0, dmem_we0;
  logic [XLEN-1:0] op_a1, op_b1, redirect_pc1, csr_tohost1;
  logic            stall1, pc_sel1, flush1, dmem_re1, dmem_we1;

  always #5 clk = ~clk;

  x_hazard_ctrl #(.XLEN(32), .FWD_DEPTH(2), .LOAD_LAT(2), .KILL_SLOTS(2), .CSR_TOHOST(12'h51E)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .x_valid(x_valid), .x_inst(x_inst), .x_pc(x_pc), .x_imm(x_imm),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .op_a(op_a0), .op_b(op_b0), .stall(stall0), .pc_sel(pc_sel0),
    .redirect_pc(redirect_pc0), .flush(flush0), .dmem_re(dmem_re0), .dmem_we(dmem_we0),
    .csr_tohost(csr_tohost0)
  );

  x_hazard_ctrl #(.XLEN(32), .FWD_DEPTH(1), .LOAD_LAT(3), .KILL_SLOTS(1), .CSR_TOHOST(12'h51E)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .x_valid(x_valid), .x_inst(x_inst), .x_pc(x_pc), .x_imm(x_imm),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .op_a(op_a1), .op_b(op_b1), .stall(stall1), .pc_sel(pc_sel1),
    .redirect_pc(redirect_pc1), .flush(flush1), .dmem_re(dmem_re1), .dmem_we(dmem_we1),
    .csr_tohost(csr_tohost1)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   step_no = 0;
  event chk_now;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      OPA0: return op_a0;
      OPB0: return op_b0;
      STL0: return 32'(stall0);
      PCS0: return 32'(pc_sel0);
      RPC0: return redirect_pc0;
      FLS0: return 32'(flush0);
      DRE0: return 32'(dmem_re0);
      DWE0: return 32'(dmem_we0);
      CSR0: return csr_tohost0;
      OPA1: return op_a1;
      OPB1: return op_b1;
      STL1: return 32'(stall1);
      PCS1: return 32'(pc_sel1);
      FLS1: return 32'(flush1);
      DRE1: return 32'(dmem_re1);
      DWE1: return 32'(dmem_we1);
      CSR1: return csr_tohost1;
      default: return 32'hXXXXXXXX;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      OPA0: return "dut0.op_a";
      OPB0: return "dut0.op_b";
      STL0: return "dut0.stall";
      PCS0: return "dut0.pc_sel";
      RPC0: return "dut0.redirect_pc";
      FLS0: return "dut0.flush";
      DRE0: return "dut0.dmem_re";
      DWE0: return "dut0.dmem_we";
      CSR0: return "dut0.csr_tohost";
      OPA1: return "dut1.op_a";
      OPB1: return "dut1.op_b";
      STL1: return "dut1.stall";
      PCS1: return "dut1.pc_sel";
      FLS1: return "dut1.flush";
      DRE1: return "dut1.dmem_re";
      DWE1: return "dut1.dmem_we";
      CSR1: return "dut1.csr_tohost";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current sample point.
  always @(negedge clk or chk_now) begin
    while (sb.size() != 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actual(e.sel);
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s step %0d: got %h expected %h", sel_name(e.sel), e.tag, act, e.exp);
      end
    end
  end

  task automatic exp_push(input int sel, input logic [31:0] v);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = step_no;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic idle();
    x_valid     = 1'b0;
    x_inst      = NOP;
    x_pc        = '0;
    x_imm       = '0;
    rf_rs1_data = '0;
    rf_rs2_data = '0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = d;
  endtask

  task automatic issue(input logic [31:0] inst);
    x_valid = 1'b1;
    x_inst  = inst;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();

    // In reset: no side effects, raw regfile operands, CSR cleared.
    cyc();
    issue(JALR); x_imm = 32'd4; rf_rs1_data = 32'h1234; wb(5'd9, 32'hAAAA);
    exp_push(OPA0, 32'h1234); exp_push(STL0, 0); exp_push(PCS0, 0);
    exp_push(RPC0, 0); exp_push(FLS0, 0); exp_push(CSR0, 0);
    cyc(); reset_n = 1'b1; idle();
    cyc(); idle();

    // History forwarding, depth 2 vs depth 1.
    cyc(); idle(); wb(5'd5, 32'd7);
    cyc(); idle();
    cyc(); issue(ADD_655);
    exp_push(OPA0, 32'd7); exp_push(OPB0, 32'd7); exp_push(OPA1, 32'd0);
    cyc(); issue(ADD_655); wb(5'd5, 32'd9);
    exp_push(OPA0, 32'd9); exp_push(OPA1, 32'd9);
    cyc(); issue(ADD_605); rf_rs1_data = 32'h1234; rf_rs2_data = 32'h1111; wb(5'd0, 32'hAAAA);
    exp_push(OPA0, 32'd0); exp_push(OPB0, 32'd9); exp_push(OPB1, 32'd9);
    repeat (3) begin cyc(); idle(); end

    // Load-use: dut0 stalls one cycle, dut1 two.
    cyc(); issue(LW_3);
    exp_push(DRE0, 1); exp_push(STL0, 0); exp_push(DRE1, 1);
    cyc(); issue(ADD_431);
    exp_push(STL0, 1); exp_push(STL1, 1); exp_push(DRE0, 0);
    cyc(); issue(ADD_431); wb(5'd3, 32'hDEADBEEF);
    exp_push(STL0, 0); exp_push(OPA0, 32'hDEADBEEF); exp_push(STL1, 1); exp_push(DRE0, 0);
    cyc(); issue(ADD_431); wb(5'd3, 32'hDEADBEEF);
    exp_push(STL1, 0); exp_push(OPA1, 32'hDEADBEEF); exp_push(STL0, 0);
    repeat (3) begin cyc(); idle(); end

    // Signed vs unsigned branch on a forwarded all-ones operand.
    cyc(); issue(BLT); x_pc = 32'h100; x_imm = 32'h40; rf_rs2_data = 32'd1; wb(5'd7, 32'hFFFFFFFF);
    exp_push(PCS0, 1); exp_push(RPC0, 32'h140); exp_push(FLS0, 1); exp_push(PCS1, 1);
    cyc(); idle(); issue(SW);
    exp_push(FLS0, 1); exp_push(DWE0, 0); exp_push(FLS1, 0); exp_push(DWE1, 1);
    cyc(); idle(); issue(BLTU); x_pc = 32'h100; x_imm = 32'h40; rf_rs2_data = 32'd1; wb(5'd7, 32'hFFFFFFFF);
    exp_push(PCS0, 0); exp_push(RPC0, 0); exp_push(FLS0, 0); exp_push(OPA0, 32'hFFFFFFFF);
    cyc(); idle();

    // JALR clears bit 0; next slot is killed in dut0.
    cyc(); issue(JALR); x_pc = 32'h200; x_imm = 32'd4; rf_rs1_data = 32'h1003;
    exp_push(PCS0, 1); exp_push(RPC0, 32'h1006); exp_push(FLS0, 1);
    cyc(); idle(); issue(SW);
    exp_push(FLS0, 1); exp_push(DWE0, 0);
    cyc(); idle();
    exp_push(FLS0, 0);

    // tohost writes: csrrw, csrrwi, then csrrs leaves it alone.
    cyc(); idle(); issue(CSRRW); wb(5'd1, 32'h55);
    exp_push(CSR0, 0);
    cyc(); idle(); issue(CSRRWI);
    exp_push(CSR0, 32'h55); exp_push(CSR1, 32'h55);
    cyc(); idle(); issue(CSRRS); rf_rs1_data = 32'h77;
    exp_push(CSR0, 32'h3);
    cyc(); idle();
    exp_push(CSR0, 32'h3); exp_push(CSR1, 32'h3);

    // Async reset in the middle of dut1's LDWAIT.
    cyc(); issue(LW_3);
    cyc(); issue(ADD_431);
    exp_push(STL1, 1); exp_push(CSR1, 32'h3);
    cyc(); issue(ADD_431);
    exp_push(STL1, 1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    exp_push(STL1, 0); exp_push(CSR1, 0); exp_push(CSR0, 0);
    -> chk_now;
    #1;
    cyc(); reset_n = 1'b1; issue(ADD_431);
    exp_push(STL1, 0); exp_push(STL0, 0);
    cyc(); idle();

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
